// File: rtl/gpio_cmd_sender_pkg.sv
// Shared definitions for the GPIO command protocol: command codes, idle code and
// sender FSM state encoding.
package gpio_cmd_sender_pkg;

    localparam logic [2:0] KERNEL_LOAD  = 3'd0;
    localparam logic [2:0] IMGSIZE_LOAD = 3'd1;
    localparam logic [2:0] IMG_LOAD     = 3'd2;
    localparam logic [2:0] DATA_REQ     = 3'd3;
    localparam logic [2:0] IMG_FINISHED = 3'd4;

    // DATA_REQ is a no-op in the control block, so it doubles as the resting code.
    localparam logic [2:0] IDLE_CTRL = DATA_REQ;

    localparam int unsigned TIMER_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StGap,
        StRead,
        StWaitSop,
        StWaitEop,
        StResp
    } state_e;

    function automatic logic is_legal_code(input logic [2:0] code);
        return code <= IMG_FINISHED;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that stops at zero; zero_o flags the last cycle of a phase
// when loaded with (phase length - 1).
module cycle_timer #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gpio_cmd_sender.sv
// Host-side GPIO command initiator: turns handshaked commands into timed
// ctrl/data/strobe transactions, captures read data and supervises runs.
module gpio_cmd_sender
    import gpio_cmd_sender_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned PULSE_CYC   = 2,
    parameter int unsigned GAP_CYC     = 2,
    parameter int unsigned READ_LAT    = 2,
    parameter int unsigned EOP_TIMEOUT = 1048576
) (
    input  logic        i_CLK,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [2:0]  i_cmd_code,
    input  logic [23:0] i_cmd_data,
    output logic [2:0]  o_GPIOctrl,
    output logic [23:0] o_GPIOdata,
    output logic        o_GPIOvalid,
    input  logic [31:0] i_GPIOdata_rd,
    input  logic        i_SoP,
    input  logic        i_EOP,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic        o_busy
);

    localparam logic [TIMER_W-1:0] SetupLoad = TIMER_W'(SETUP_CYC - 1);
    localparam logic [TIMER_W-1:0] PulseLoad = TIMER_W'(PULSE_CYC - 1);
    localparam logic [TIMER_W-1:0] GapLoad   = TIMER_W'(GAP_CYC - 1);
    localparam logic [TIMER_W-1:0] ReadLoad  = TIMER_W'(READ_LAT - 1);
    localparam logic [31:0]        TimeoutCnt = 32'(EOP_TIMEOUT);

    state_e       state_d, state_q;
    logic [2:0]   ctrl_d, ctrl_q;
    logic [23:0]  data_d, data_q;
    logic [2:0]   code_d, code_q;
    logic         rsp_valid_d, rsp_valid_q;
    logic [31:0]  rsp_data_d, rsp_data_q;
    logic         rsp_err_d, rsp_err_q;
    logic [31:0]  sup_d, sup_q;
    logic [31:0]  sup_inc;
    logic         supervising;
    logic         timeout;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_zero;

    cycle_timer #(
        .Width (TIMER_W)
    ) u_timer (
        .clk_i      (i_CLK),
        .rst_i      (i_rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    assign supervising = (state_q == StWaitSop) || (state_q == StWaitEop);
    assign sup_inc     = (sup_q == '1) ? sup_q : sup_q + 32'd1;
    // Value the counter holds after this cycle's increment; reported at exit.
    assign timeout     = supervising && (sup_inc >= TimeoutCnt);

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        data_d      = data_q;
        code_d      = code_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        sup_d       = supervising ? sup_inc : sup_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        unique case (state_q)
            StIdle: begin
                if (i_cmd_valid) begin
                    code_d = i_cmd_code;
                    if (is_legal_code(i_cmd_code)) begin
                        ctrl_d   = i_cmd_code;
                        data_d   = i_cmd_data;
                        tmr_load = 1'b1;
                        tmr_val  = SetupLoad;
                        state_d  = StSetup;
                    end else begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = StResp;
                    end
                end
            end
            StSetup: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (code_q == DATA_REQ) begin
                        tmr_val = ReadLoad;
                        state_d = StRead;
                    end else begin
                        tmr_val = PulseLoad;
                        state_d = StPulse;
                    end
                end
            end
            StPulse: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = GapLoad;
                    state_d  = StGap;
                end
            end
            StGap: begin
                if (tmr_zero) begin
                    if (code_q == IMG_FINISHED) begin
                        sup_d   = '0;
                        state_d = StWaitSop;
                    end else begin
                        ctrl_d  = IDLE_CTRL;
                        state_d = StIdle;
                    end
                end
            end
            StRead: begin
                if (tmr_zero) begin
                    rsp_data_d = i_GPIOdata_rd;
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end
            end
            StWaitSop: begin
                if (timeout) begin
                    rsp_data_d = sup_inc;
                    rsp_err_d  = 1'b1;
                    state_d    = StResp;
                end else if (i_SoP) begin
                    state_d = StWaitEop;
                end
            end
            StWaitEop: begin
                // EOP is sticky upstream, so only a fall of SoP with EOP set ends the run.
                if (timeout) begin
                    rsp_data_d = sup_inc;
                    rsp_err_d  = 1'b1;
                    state_d    = StResp;
                end else if (!i_SoP && i_EOP) begin
                    rsp_data_d = sup_inc;
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end
            end
            StResp: begin
                // First cycle raises the strobe, second cycle retires to idle.
                ctrl_d = IDLE_CTRL;
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                ctrl_d  = IDLE_CTRL;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            ctrl_q      <= IDLE_CTRL;
            data_q      <= '0;
            code_q      <= IDLE_CTRL;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            sup_q       <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
            code_q      <= code_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            sup_q       <= sup_d;
        end
    end

    assign o_cmd_ready = (state_q == StIdle);
    assign o_busy      = (state_q != StIdle);
    assign o_GPIOvalid = (state_q == StPulse);
    assign o_GPIOctrl  = ctrl_q;
    assign o_GPIOdata  = data_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_gpio_cmd_sender.sv
// Randomized bench for gpio_cmd_sender: command timelines predicted from the
// protocol timing rules, plus directed reset, run-supervision and timeout cases.
module tb_gpio_cmd_sender;

    localparam int S  = 2;
    localparam int P  = 2;
    localparam int G  = 2;
    localparam int L  = 2;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_code;
    logic [23:0] cmd_data;
    logic [2:0]  gpio_ctrl;
    logic [23:0] gpio_data;
    logic        gpio_valid;
    logic [31:0] gpio_rd;
    logic        sop;
    logic        eop;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [23:0] model_data;

    gpio_cmd_sender #(
        .SETUP_CYC   (S),
        .PULSE_CYC   (P),
        .GAP_CYC     (G),
        .READ_LAT    (L),
        .EOP_TIMEOUT (TO)
    ) dut (
        .i_CLK         (clk),
        .i_rst         (rst),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_code    (cmd_code),
        .i_cmd_data    (cmd_data),
        .o_GPIOctrl    (gpio_ctrl),
        .o_GPIOdata    (gpio_data),
        .o_GPIOvalid   (gpio_valid),
        .i_GPIOdata_rd (gpio_rd),
        .i_SoP         (sop),
        .i_EOP         (eop),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_data    (rsp_data),
        .o_rsp_err     (rsp_err),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [2:0] code, input logic [23:0] d);
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Walk one command from its accept edge (k = 0) until ready returns, checking
    // every output against the timing rules of the protocol.
    task automatic run_cmd(input logic [2:0] code, input logic [23:0] d, input logic [31:0] rd);
        logic legal, is_wr, is_rd;
        int   last, rsp_k;
        logic [2:0]  e_ctrl;
        logic [23:0] e_data;
        legal = (code <= 3'd4);
        is_wr = (code <= 3'd2);
        is_rd = (code == 3'd3);
        last  = is_wr ? S + P + G : (is_rd ? S + L + 2 : 2);
        rsp_k = is_rd ? S + L + 1 : (legal ? -1 : 1);
        check_eq("ready_before_cmd", cmd_ready, 1);
        gpio_rd = rd;
        accept(code, d);
        for (int k = 0; k <= last; k++) begin
            e_ctrl = (is_wr && k < S + P + G) ? code : 3'd3;
            e_data = legal ? d : model_data;
            check_eq("ctrl", gpio_ctrl, e_ctrl);
            check_eq("data", gpio_data, e_data);
            check_eq("strobe", gpio_valid, (is_wr && k >= S && k < S + P));
            check_eq("ready", cmd_ready, (k == last));
            check_eq("busy", busy, (k != last));
            check_eq("rsp_valid", rsp_valid, (k == rsp_k));
            if (k == rsp_k) begin
                check_eq("rsp_data", rsp_data, is_rd ? rd : 32'd0);
                check_eq("rsp_err", rsp_err, !legal);
            end
            if (k < last) tick();
        end
        if (legal) model_data = d;
    endtask

    initial begin
        int   n;
        logic seen_early;
        logic got_rsp;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_code  = 3'd0;
        cmd_data  = '0;
        gpio_rd   = '0;
        sop       = 1'b0;
        eop       = 1'b0;
        model_data = '0;
        #12;
        check_eq("rst_ctrl", gpio_ctrl, 3);
        check_eq("rst_data", gpio_data, 0);
        check_eq("rst_strobe", gpio_valid, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        check_eq("rst_ready", cmd_ready, 1);
        check_eq("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Directed kernel load, then a read and an illegal code.
        run_cmd(3'd0, 24'h123456, 32'h0);
        tick();
        run_cmd(3'd3, 24'h000abc, 32'hdeadbeef);
        tick();
        run_cmd(3'd6, 24'h777777, 32'h0);

        // Asynchronous reset in the middle of a strobe.
        tick();
        accept(3'd1, 24'h00beef);
        tick();
        tick();
        check_eq("pre_rst_strobe", gpio_valid, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_strobe", gpio_valid, 0);
        check_eq("arst_ctrl", gpio_ctrl, 3);
        check_eq("arst_data", gpio_data, 0);
        check_eq("arst_ready", cmd_ready, 1);
        check_eq("arst_busy", busy, 0);
        #1 rst = 1'b0;
        model_data = '0;
        tick();

        // Randomized command mix.
        for (int i = 0; i < 40; i++) begin
            int r;
            logic [2:0] c;
            r = $urandom_range(0, 9);
            if (r < 6) c = 3'(r % 3);
            else if (r < 8) c = 3'd3;
            else c = 3'(5 + $urandom_range(0, 2));
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) tick();
            run_cmd(c, 24'($urandom), $urandom);
        end

        // Start with a stale EOP: response only after SoP rises then falls.
        tick();
        eop = 1'b1;
        accept(3'd4, 24'h000004);
        for (int k = 1; k <= S + P + G; k++) tick();
        check_eq("start_ctrl", gpio_ctrl, 4);
        seen_early = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rsp_valid) seen_early = 1'b1;
        end
        sop = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (rsp_valid) seen_early = 1'b1;
        end
        check_eq("start_no_early_rsp", seen_early, 0);
        sop = 1'b0;
        got_rsp = 1'b0;
        for (int k = 0; k < 20 && !got_rsp; k++) begin
            tick();
            if (rsp_valid) got_rsp = 1'b1;
        end
        check_eq("start_rsp_seen", got_rsp, 1);
        check_eq("start_err", rsp_err, 0);
        check_eq("start_count_50pm1", (rsp_data >= 49 && rsp_data <= 51), 1);
        tick();
        check_eq("start_ctrl_idle", gpio_ctrl, 3);
        check_eq("start_ready", cmd_ready, 1);

        // Start that never sees SoP: supervision times out.
        eop = 1'b0;
        tick();
        accept(3'd4, 24'h000005);
        for (int k = 1; k <= S + P + G; k++) tick();
        n = 0;
        got_rsp = 1'b0;
        while (!got_rsp && n < 3 * TO) begin
            tick();
            n++;
            if (rsp_valid) got_rsp = 1'b1;
        end
        check_eq("to_rsp_seen", got_rsp, 1);
        check_eq("to_latency", (n == TO || n == TO + 1), 1);
        check_eq("to_err", rsp_err, 1);
        check_eq("to_count", rsp_data, TO);
        tick();
        check_eq("to_ctrl_idle", gpio_ctrl, 3);
        check_eq("to_ready", cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
